// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry FIFO of fetched {inst, pc} pairs. The head entry is decoded
// combinationally into register indices, immediate and instruction class.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int M_EXT = 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_imm,
    output logic [3:0]               out_class,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic M_EN = M_EXT[0];

    localparam logic [3:0] CLS_BUBBLE  = 4'd0;
    localparam logic [3:0] CLS_ALU_R   = 4'd1;
    localparam logic [3:0] CLS_ALU_I   = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JAL     = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_LUI     = 4'd8;
    localparam logic [3:0] CLS_AUIPC   = 4'd9;
    localparam logic [3:0] CLS_MULDIV  = 4'd10;
    localparam logic [3:0] CLS_CSR     = 4'd11;
    localparam logic [3:0] CLS_SYSTEM  = 4'd12;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    logic [31:0]     inst_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        push_s;
    logic        pop_s;
    logic [31:0] head_inst_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [3:0]  dec_class_s;
    logic [4:0]  dec_rs1_s;
    logic [4:0]  dec_rs2_s;
    logic [4:0]  dec_rd_s;
    logic [31:0] dec_imm_s;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;

    assign head_inst_s = inst_mem_q[rd_ptr_q];
    assign opcode_s    = head_inst_s[6:0];
    assign funct3_s    = head_inst_s[14:12];
    assign funct7_s    = head_inst_s[31:25];

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            inst_mem_q[wr_ptr_q] <= in_inst;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

    // Next-state pointers and count; flush discards everything including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Instruction class of the head entry.
    always_comb begin
        dec_class_s = CLS_ILLEGAL;
        if (head_inst_s[1:0] == 2'b11) begin
            case (opcode_s)
                7'b0110011: begin
                    if (funct7_s == 7'b0000000 || funct7_s == 7'b0100000) begin
                        dec_class_s = CLS_ALU_R;
                    end else if (funct7_s == 7'b0000001 && M_EN) begin
                        dec_class_s = CLS_MULDIV;
                    end else begin
                        dec_class_s = CLS_ILLEGAL;
                    end
                end
                7'b0010011: begin
                    if ((funct3_s == 3'd1 || funct3_s == 3'd5) &&
                        !(funct7_s == 7'b0000000 || funct7_s == 7'b0100000)) begin
                        dec_class_s = CLS_ILLEGAL;
                    end else begin
                        dec_class_s = CLS_ALU_I;
                    end
                end
                7'b0000011: begin
                    case (funct3_s)
                        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: dec_class_s = CLS_LOAD;
                        default:                      dec_class_s = CLS_ILLEGAL;
                    endcase
                end
                7'b0100011: begin
                    case (funct3_s)
                        3'd0, 3'd1, 3'd2: dec_class_s = CLS_STORE;
                        default:          dec_class_s = CLS_ILLEGAL;
                    endcase
                end
                7'b1100011: begin
                    case (funct3_s)
                        3'd2, 3'd3: dec_class_s = CLS_ILLEGAL;
                        default:    dec_class_s = CLS_BRANCH;
                    endcase
                end
                7'b1101111: dec_class_s = CLS_JAL;
                7'b1100111: begin
                    if (funct3_s == 3'd0) begin
                        dec_class_s = CLS_JALR;
                    end else begin
                        dec_class_s = CLS_ILLEGAL;
                    end
                end
                7'b0110111: dec_class_s = CLS_LUI;
                7'b0010111: dec_class_s = CLS_AUIPC;
                7'b1110011: begin
                    if (funct3_s != 3'd0 && funct3_s != 3'd4) begin
                        dec_class_s = CLS_CSR;
                    end else if (head_inst_s == 32'h0000_0073 || head_inst_s == 32'h0010_0073 ||
                                 head_inst_s == 32'h3020_0073) begin
                        dec_class_s = CLS_SYSTEM;
                    end else begin
                        dec_class_s = CLS_ILLEGAL;
                    end
                end
                default: dec_class_s = CLS_ILLEGAL;
            endcase
        end else begin
            dec_class_s = CLS_ILLEGAL;
        end
    end

    // Register and immediate fields, zeroed where the format has no such field.
    always_comb begin
        dec_rs1_s = 5'd0;
        dec_rs2_s = 5'd0;
        dec_rd_s  = 5'd0;
        dec_imm_s = 32'd0;
        case (dec_class_s)
            CLS_ALU_R, CLS_MULDIV: begin
                dec_rs1_s = head_inst_s[19:15];
                dec_rs2_s = head_inst_s[24:20];
                dec_rd_s  = head_inst_s[11:7];
            end
            CLS_ALU_I, CLS_LOAD, CLS_JALR, CLS_SYSTEM: begin
                dec_rs1_s = head_inst_s[19:15];
                dec_rd_s  = head_inst_s[11:7];
                dec_imm_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
            end
            CLS_CSR: begin
                dec_rs1_s = head_inst_s[19:15];
                dec_rd_s  = head_inst_s[11:7];
                dec_imm_s = {20'd0, head_inst_s[31:20]};
            end
            CLS_STORE: begin
                dec_rs1_s = head_inst_s[19:15];
                dec_rs2_s = head_inst_s[24:20];
                dec_imm_s = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
            end
            CLS_BRANCH: begin
                dec_rs1_s = head_inst_s[19:15];
                dec_rs2_s = head_inst_s[24:20];
                dec_imm_s = {{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                             head_inst_s[30:25], head_inst_s[11:8], 1'b0};
            end
            CLS_LUI, CLS_AUIPC: begin
                dec_rd_s  = head_inst_s[11:7];
                dec_imm_s = {head_inst_s[31:12], 12'd0};
            end
            CLS_JAL: begin
                dec_rd_s  = head_inst_s[11:7];
                dec_imm_s = {{11{head_inst_s[31]}}, head_inst_s[31], head_inst_s[19:12],
                             head_inst_s[20], head_inst_s[30:21], 1'b0};
            end
            default: begin
                dec_rs1_s = 5'd0;
                dec_rs2_s = 5'd0;
                dec_rd_s  = 5'd0;
                dec_imm_s = 32'd0;
            end
        endcase
    end

    // Present the decoded head, or an all-zero bubble when the queue is empty.
    always_comb begin
        out_inst    = 32'd0;
        out_pc      = '0;
        out_rs1     = 5'd0;
        out_rs2     = 5'd0;
        out_rd      = 5'd0;
        out_imm     = 32'd0;
        out_class   = CLS_BUBBLE;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_inst    = head_inst_s;
            out_pc      = pc_mem_q[rd_ptr_q];
            out_rs1     = dec_rs1_s;
            out_rs2     = dec_rs2_s;
            out_rd      = dec_rd_s;
            out_imm     = dec_imm_s;
            out_class   = dec_class_s;
            out_illegal = (dec_class_s == CLS_ILLEGAL);
        end else begin
            out_class   = CLS_BUBBLE;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-based reference model checked every cycle against two
// instances (RV32M enabled and disabled), plus directed literal checks.
module tb_decode_queue;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_illegal0;
    logic [31:0] out_inst0, out_pc0, out_imm0;
    logic [4:0]  out_rs1_0, out_rs2_0, out_rd0;
    logic [3:0]  out_class0;
    logic [2:0]  count0;

    logic        in_ready1, out_valid1, out_illegal1;
    logic [31:0] out_inst1, out_pc1, out_imm1;
    logic [4:0]  out_rs1_1, out_rs2_1, out_rd1;
    logic [3:0]  out_class1;
    logic [2:0]  count1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t mq[$];

    logic [31:0] prog [16] = '{
        32'h0000_0013, 32'h0000_A103, 32'h0020_A023, 32'h0000_0463,
        32'h0080_00EF, 32'h0000_80E7, 32'h1234_52B7, 32'h0000_1317,
        32'h3000_2573, 32'h0000_0073, 32'h4010_D093, 32'h0200_D093,
        32'h0000_2063, 32'hFFFF_FFFF, 32'h0000_0012, 32'h3020_0073
    };

    decode_queue #(.DEPTH(4), .PC_W(32), .M_EXT(1)) dut0 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
        .out_inst(out_inst0), .out_pc(out_pc0), .out_rs1(out_rs1_0), .out_rs2(out_rs2_0),
        .out_rd(out_rd0), .out_imm(out_imm0), .out_class(out_class0),
        .out_illegal(out_illegal0), .count(count0)
    );

    decode_queue #(.DEPTH(4), .PC_W(32), .M_EXT(0)) dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
        .out_inst(out_inst1), .out_pc(out_pc1), .out_rs1(out_rs1_1), .out_rs2(out_rs2_1),
        .out_rd(out_rd1), .out_imm(out_imm1), .out_class(out_class1),
        .out_illegal(out_illegal1), .count(count1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference decode straight from the opcode table, by instruction format.
    function automatic void model_decode(input logic [31:0] i, input bit mext,
                                         output logic [3:0] cls, output logic [4:0] rs1,
                                         output logic [4:0] rs2, output logic [4:0] rd,
                                         output logic [31:0] imm);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [12:0] b;
        logic [20:0] j;
        logic [11:0] s;
        int fmt;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        cls = 4'd15;
        fmt = 0;
        if (i[1:0] == 2'b11) begin
            case (op)
                7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin cls = 4'd1; fmt = 1; end
                       else if (f7 == 7'h01 && mext) begin cls = 4'd10; fmt = 1; end
                7'h13: if ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || f7 == 7'h20) begin
                           cls = 4'd2; fmt = 2;
                       end
                7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin cls = 4'd3; fmt = 2; end
                7'h23: if (f3 <= 3'd2) begin cls = 4'd4; fmt = 3; end
                7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin cls = 4'd5; fmt = 4; end
                7'h6F: begin cls = 4'd6; fmt = 6; end
                7'h67: if (f3 == 3'd0) begin cls = 4'd7; fmt = 2; end
                7'h37: begin cls = 4'd8; fmt = 5; end
                7'h17: begin cls = 4'd9; fmt = 5; end
                7'h73: if (f3 != 3'd0 && f3 != 3'd4) begin cls = 4'd11; fmt = 7; end
                       else if (i == 32'h73 || i == 32'h0010_0073 || i == 32'h3020_0073) begin
                           cls = 4'd12; fmt = 2;
                       end
                default: ;
            endcase
        end
        rs1 = (fmt inside {1, 2, 3, 4, 7}) ? i[19:15] : 5'd0;
        rs2 = (fmt inside {1, 3, 4}) ? i[24:20] : 5'd0;
        rd  = (fmt inside {1, 2, 5, 6, 7}) ? i[11:7] : 5'd0;
        s = {i[31:25], i[11:7]};
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (fmt)
            2: imm = 32'($signed(i[31:20]));
            3: imm = 32'($signed(s));
            4: imm = 32'($signed(b));
            5: imm = i & 32'hFFFF_F000;
            6: imm = 32'($signed(j));
            7: imm = i >> 20;
            default: imm = 32'd0;
        endcase
    endfunction

    // One clock: decide push/pop from the model's state, then update it after the edge.
    task automatic step();
        bit push, pop;
        push = in_valid && (mq.size() < 4) && !flush;
        pop  = (mq.size() > 0) && out_ready && !flush;
        @(posedge CLK);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{inst: in_inst, pc: in_pc});
        end
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin : cmp
        logic [31:0] hi, hp, imm_e;
        logic [3:0]  cls_e;
        logic [4:0]  rs1_e, rs2_e, rd_e;
        bit v;
        v  = mq.size() > 0;
        hi = v ? mq[0].inst : 32'd0;
        hp = v ? mq[0].pc : 32'd0;
        chk("valid", {31'd0, out_valid0}, {31'd0, v});
        chk("ready", {31'd0, in_ready0}, {31'd0, mq.size() != 4});
        chk("count", {29'd0, count0}, 32'(mq.size()));
        chk("inst", out_inst0, hi);
        chk("pc", out_pc0, hp);
        model_decode(hi, 1'b1, cls_e, rs1_e, rs2_e, rd_e, imm_e);
        if (!v) begin
            cls_e = 4'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0; imm_e = 32'd0;
        end
        chk("class", {28'd0, out_class0}, {28'd0, cls_e});
        chk("illegal", {31'd0, out_illegal0}, {31'd0, cls_e == 4'd15});
        chk("rs1", {27'd0, out_rs1_0}, {27'd0, rs1_e});
        chk("rs2", {27'd0, out_rs2_0}, {27'd0, rs2_e});
        chk("rd", {27'd0, out_rd0}, {27'd0, rd_e});
        chk("imm", out_imm0, imm_e);
        model_decode(hi, 1'b0, cls_e, rs1_e, rs2_e, rd_e, imm_e);
        if (!v) begin
            cls_e = 4'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0; imm_e = 32'd0;
        end
        chk("nom_count", {29'd0, count1}, 32'(mq.size()));
        chk("nom_pc", out_pc1, hp);
        chk("nom_class", {28'd0, out_class1}, {28'd0, cls_e});
        chk("nom_illegal", {31'd0, out_illegal1}, {31'd0, cls_e == 4'd15});
        chk("nom_rd", {27'd0, out_rd1}, {27'd0, rd_e});
        chk("nom_rs", {22'd0, out_rs1_1, out_rs2_1}, {22'd0, rs1_e, rs2_e});
        chk("nom_imm", out_imm1, imm_e);
    end

    initial begin
        logic [3:0]  c;
        logic [4:0]  r1, r2, rd;
        logic [31:0] im;

        model_decode(32'hFFF0_0093, 1'b1, c, r1, r2, rd, im);
        chk("model_addi", {c, 3'd0, rd, r1, im[18:0]}, {4'd2, 3'd0, 5'd1, 5'd0, 19'h7FFFF});
        model_decode(32'h3000_2573, 1'b1, c, r1, r2, rd, im);
        chk("model_csr", {c, 3'd0, rd, im[19:0]}, {4'd11, 3'd0, 5'd10, 20'h00300});
        model_decode(32'h0000_A103, 1'b1, c, r1, r2, rd, im);
        chk("model_lw", {c, 8'd0, rd, r1, r2, 5'd0}, {4'd3, 8'd0, 5'd2, 5'd1, 5'd0, 5'd0});

        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        #1;
        chk("rst_count", {29'd0, count0}, 32'd0);
        chk("rst_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_class", {28'd0, out_class0}, 32'd0);

        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h100; out_ready = 1'b0;
        #1 chk("no_bypass", {31'd0, out_valid0}, 32'd0);
        step();
        chk("addi_valid", {31'd0, out_valid0}, 32'd1);
        chk("addi_class", {28'd0, out_class0}, 32'd2);
        chk("addi_rd_rs1", {22'd0, out_rd0, out_rs1_0}, {22'd0, 5'd1, 5'd0});
        chk("addi_imm", out_imm0, 32'hFFFF_FFFF);

        in_inst = 32'h0020_8133; in_pc = 32'h104; step();
        in_inst = 32'h0220_81B3; in_pc = 32'h108; step();
        in_inst = 32'h0000_0000; in_pc = 32'h10C; step();
        chk("full_count", {29'd0, count0}, 32'd4);
        chk("full_ready", {31'd0, in_ready0}, 32'd0);
        in_inst = 32'h0000_0013; in_pc = 32'h110; step();
        chk("fifth_count", {29'd0, count0}, 32'd4);
        chk("fifth_head", out_pc0, 32'h100);

        out_ready = 1'b1; step();
        chk("full_pop_count", {29'd0, count0}, 32'd3);
        chk("full_pop_head", out_inst0, 32'h0020_8133);
        step();
        chk("mul_m1_class", {28'd0, out_class0}, 32'd10);
        chk("mul_m1_rd", {27'd0, out_rd0}, 32'd3);
        chk("mul_m0_class", {28'd0, out_class1}, 32'd15);
        chk("mul_m0_illegal", {31'd0, out_illegal1}, 32'd1);
        chk("mul_m0_rd", {27'd0, out_rd1}, 32'd0);
        in_inst = prog[0]; in_pc = 32'h114; step();
        chk("zero_class", {28'd0, out_class0}, 32'd15);
        chk("zero_illegal", {31'd0, out_illegal0}, 32'd1);

        for (int k = 0; k < 20; k++) begin
            in_inst = prog[k % 16];
            in_pc   = 32'h200 + 32'(4 * k);
            step();
        end
        chk("steady_count", {29'd0, count0}, 32'd3);

        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 32'hDEAD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", {29'd0, count0}, 32'd0);
        chk("flush_valid", {31'd0, out_valid0}, 32'd0);
        step();
        chk("flush_dropped", {31'd0, out_valid0}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_inst = prog[k + 4];
            in_pc   = 32'h300 + 32'(4 * k);
            step();
        end
        chk("pre_rst_count", {29'd0, count0}, 32'd3);
        in_valid = 1'b0;
        #1 nRST = 1'b0;
        mq.delete();
        #1;
        chk("arst_count", {29'd0, count0}, 32'd0);
        chk("arst_valid", {31'd0, out_valid0}, 32'd0);
        chk("arst_ready", {31'd0, in_ready0}, 32'd1);
        @(posedge CLK);
        #1 nRST = 1'b1;

        in_valid = 1'b1; in_inst = 32'h3000_2573; in_pc = 32'h400; step();
        in_valid = 1'b0;
        chk("csr_class", {28'd0, out_class0}, 32'd11);
        chk("csr_imm", out_imm0, 32'h300);
        chk("csr_rd", {27'd0, out_rd0}, 32'd10);
        out_ready = 1'b1; step();
        chk("drain_valid", {31'd0, out_valid0}, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
